stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Controller and sequencer for a two-digit BCD elapsed-time counter (units + tens).
//  Decodes start/stop/clear/lap command pulses into a run state machine.
//  Generates the divided count tick internally and cascades units into tens.
//  Drives display-ready digits, with an optional frozen "lap" snapshot.
//  Sits between the push-button debouncers and the 7-segment digit mux.
// PARAMETERS
//  TICK_DIV  11  clk cycles per count step; legal range >= 1.
//  TENS_MAX  5   highest tens digit; legal range 0..9. Default span is 00..59.
// PORTS
//  clk        in   1  system clock; all state changes on posedge.
//  reset      in   1  synchronous, active-low reset (0 = reset).
//  start      in   1  one-cycle command pulse: run / resume.
//  stop       in   1  one-cycle command pulse: pause.
//  clear      in   1  one-cycle command pulse: zero the count and go idle.
//  lap        in   1  one-cycle command pulse: freeze or release the displayed value.
//  units      out  4  displayed units digit, BCD 0..9.
//  tens       out  4  displayed tens digit, BCD 0..TENS_MAX.
//  running    out  1  1 in state RUN or LAP.
//  lap_active out  1  1 in state LAP (display frozen).
//  wrap       out  1  one-cycle pulse when the live count rolls over from TENS_MAX:9 to 00.
// BEHAVIOUR
//  Reset
//   - reset==0 at a posedge: state=IDLE, prescaler=0, live count=00, lap latch=00.
//   - Outputs after reset: running=0, lap_active=0, wrap=0, units=0, tens=0.
//   - Reset overrides all commands and is honoured in any state, including mid-run.
//  State machine: IDLE, RUN, PAUSE, LAP
//   - Command priority within a cycle: clear > stop > start > lap.
//   - Only the highest-priority command that is meaningful in the current state acts.
//   - IDLE : start -> RUN. Ignores stop, lap and clear.
//   - RUN  : clear -> IDLE (zero). stop -> PAUSE. lap -> LAP (latch live count). start ignored.
//   - PAUSE: clear -> IDLE (zero). start -> RUN. stop and lap ignored.
//   - LAP  : clear -> IDLE (zero). stop -> PAUSE (display returns to live count).
//            lap -> RUN (release the freeze). start ignored.
//  Prescaler and tick
//   - The prescaler counts 0..TICK_DIV-1 on every posedge while state is RUN or LAP.
//   - When it sits at TICK_DIV-1 it wraps to 0 and the live count steps (tick).
//   - In PAUSE the prescaler holds, so a resume keeps the partial period.
//   - clear and reset zero the prescaler.
//   - Ticks use the state held before the edge: a stop and a tick on the same edge still count.
//   - Prescaler width is max(1, $clog2(TICK_DIV)).
//   - TICK_DIV==1 gives a tick on every RUN/LAP cycle.
//  Count arithmetic (BCD)
//   - units 0..8 -> +1.
//   - units 9 -> units 0 and tens +1.
//   - tens==TENS_MAX with units 9 -> 00, and wrap=1 for that cycle only.
//   - The live count never leaves legal BCD; the run state is unchanged by a wrap.
//  Latency
//   - Command sampled at edge n -> new state and the running/lap_active outputs are valid after edge n.
//   - start sampled at edge n (from 00) -> units=1 after edge n+TICK_DIV.
//   - All outputs are registered; there is no combinational path from inputs to outputs.
//  Display
//   - units/tens show the lap latch in state LAP, otherwise the live count.
//   - The live count keeps advancing during LAP.
//   - wrap follows the live count even while the display is frozen.
// TESTING (TICK_DIV=4, TENS_MAX=5 unless noted)
//  1. Hold reset=0 for 3 cycles, then 1 -> units=0, tens=0, running=0, wrap=0. Pulse stop/lap in IDLE -> no change.
//  2. start at edge 0 -> running=1 after edge 0. units=1 after edge 4, units=2 after edge 8.
//     units 9->0 with tens=1 after edge 40.
//  3. Run to 59, then one more tick -> 00 with wrap=1 for exactly one cycle. running stays 1.
//  4. stop at prescaler=2 -> counts held over 20 cycles. start -> next tick 2 cycles after the resume edge.
//  5. lap at 12 -> display held at 12 while the live count advances.
//     lap again at live 15 -> display shows 15. In LAP, stop -> PAUSE showing the live value.
//  6. clear+stop+start in the same cycle during RUN -> IDLE, 00.
//     reset=0 mid-run at 37 -> 00, IDLE on the next edge.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Two-digit BCD stopwatch controller: decodes start/stop/clear/lap command
// pulses into a run state machine, divides the clock into count ticks,
// cascades units into tens and presents either the live count or a frozen
// lap snapshot to the digit mux.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 11,
    parameter int TENS_MAX = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] units,
    output logic [3:0] tens,
    output logic       running,
    output logic       lap_active,
    output logic       wrap
);

    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
    localparam logic [3:0] TENS_TOP = 4'(TENS_MAX);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_LAP   = 2'd3;

    logic [1:0]      state;
    logic [1:0]      state_nx;
    logic            zero_req;
    logic            latch_req;
    logic [PS_W-1:0] prescale;
    logic            counting;
    logic            tick;
    logic [3:0]      live_units;
    logic [3:0]      live_tens;
    logic [3:0]      lap_units;
    logic [3:0]      lap_tens;
    logic [8:0]      step_res;

    // One BCD count step: returns {rollover, tens, units}. The tens
    // comparison uses >= so an out-of-range tens value still returns to 00.
    function automatic logic [8:0] bcd_step(input logic [3:0] t, input logic [3:0] u);
        logic [8:0] r;
        if (u < 4'd9) begin
            r = {1'b0, t, u + 4'd1};
        end else if (t >= TENS_TOP) begin
            r = {1'b1, 4'd0, 4'd0};
        end else begin
            r = {1'b0, t + 4'd1, 4'd0};
        end
        return r;
    endfunction

    assign counting = (state == ST_RUN) || (state == ST_LAP);
    assign tick     = counting && (prescale == PS_LAST);
    assign step_res = bcd_step(live_tens, live_units);

    // Command decode: in each state only the commands that mean something
    // there are looked at, in clear > stop > start > lap order.
    always_comb begin
        state_nx  = state;
        zero_req  = 1'b0;
        latch_req = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (clear) begin
                    state_nx = ST_IDLE;
                    zero_req = 1'b1;
                end else if (stop) begin
                    state_nx = ST_PAUSE;
                end else if (lap) begin
                    state_nx  = ST_LAP;
                    latch_req = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (clear) begin
                    state_nx = ST_IDLE;
                    zero_req = 1'b1;
                end else if (start) begin
                    state_nx = ST_RUN;
                end
            end
            ST_LAP: begin
                if (clear) begin
                    state_nx = ST_IDLE;
                    zero_req = 1'b1;
                end else if (stop) begin
                    state_nx = ST_PAUSE;
                end else if (lap) begin
                    state_nx = ST_RUN;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                zero_req = 1'b1;
            end
        endcase
    end

    // Run state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Prescaler: advances while counting (state before the edge), holds in
    // PAUSE so a resume keeps the partial period, zeroed by clear.
    always_ff @(posedge clk) begin
        if (!reset || zero_req) begin
            prescale <= '0;
        end else if (counting) begin
            if (prescale == PS_LAST) begin
                prescale <= '0;
            end else begin
                prescale <= prescale + PS_W'(1);
            end
        end
    end

    // Live BCD count and its one-cycle rollover pulse.
    always_ff @(posedge clk) begin
        if (!reset || zero_req) begin
            live_units <= 4'd0;
            live_tens  <= 4'd0;
            wrap       <= 1'b0;
        end else if (tick) begin
            live_units <= step_res[3:0];
            live_tens  <= step_res[7:4];
            wrap       <= step_res[8];
        end else begin
            wrap       <= 1'b0;
        end
    end

    // Lap snapshot: captures the value on display at the moment lap is taken.
    always_ff @(posedge clk) begin
        if (!reset || zero_req) begin
            lap_units <= 4'd0;
            lap_tens  <= 4'd0;
        end else if (latch_req) begin
            lap_units <= live_units;
            lap_tens  <= live_tens;
        end
    end

    // Outputs are decoded from registers only.
    assign running    = counting;
    assign lap_active = (state == ST_LAP);
    assign units      = lap_active ? lap_units : live_units;
    assign tens       = lap_active ? lap_tens : live_tens;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus a randomized command
// stream, all checked against a seconds-based reference model.
module tb_stopwatch_ctrl;

    localparam int TD   = 4;
    localparam int TM   = 5;
    localparam int SPAN = (TM + 1) * 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic       lap = 1'b0;
    logic [3:0] units;
    logic [3:0] tens;
    logic       running;
    logic       lap_active;
    logic       wrap;

    int total = 0;
    int bad = 0;

    // Model: mode 0 idle, 1 run, 2 pause, 3 lap; count held as whole seconds.
    int m_mode = 0;
    int m_secs = 0;
    int m_phase = 0;
    int m_lapv = 0;
    bit m_wrap = 0;
    // next mode per [mode][command], command order clear, stop, start, lap; -1 = ignored
    int nxt [4][4] = '{'{-1, -1, 1, -1},
                       '{ 0,  2, -1, 3},
                       '{ 0, -1, 1, -1},
                       '{ 0,  2, -1, 1}};

    stopwatch_ctrl #(.TICK_DIV(TD), .TENS_MAX(TM)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .lap(lap),
        .units(units), .tens(tens), .running(running), .lap_active(lap_active), .wrap(wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] model_out();
        int d;
        d = (m_mode == 3) ? m_lapv : m_secs;
        return {4'(d / 10), 4'(d % 10), (m_mode == 1 || m_mode == 3), (m_mode == 3), m_wrap};
    endfunction

    function automatic logic [10:0] dut_out();
        return {tens, units, running, lap_active, wrap};
    endfunction

    // Drive one cycle of commands, advance the model across the edge, settle.
    task automatic step(input bit s, input bit p, input bit c, input bit l, input bit r);
        bit cmd [4];
        int nm;
        int act;
        int old;
        start = s; stop = p; clear = c; lap = l; reset = r;
        @(posedge clk);
        if (!r) begin
            m_mode = 0; m_secs = 0; m_phase = 0; m_lapv = 0; m_wrap = 0;
        end else begin
            cmd = '{c, p, s, l};
            act = -1;
            nm = m_mode;
            for (int k = 0; k < 4; k++) begin
                if (act < 0 && cmd[k] && nxt[m_mode][k] >= 0) begin
                    act = k;
                    nm = nxt[m_mode][k];
                end
            end
            old = m_secs;
            m_wrap = 0;
            if (m_mode == 1 || m_mode == 3) begin
                m_phase = m_phase + 1;
                if (m_phase == TD) begin
                    m_phase = 0;
                    m_secs = (m_secs + 1) % SPAN;
                    m_wrap = (m_secs == 0);
                end
            end
            if (act == 3 && m_mode == 1) m_lapv = old;
            if (act == 0) begin
                m_secs = 0; m_phase = 0; m_wrap = 0; m_lapv = 0;
            end
            m_mode = nm;
        end
        #1;
        start = 0; stop = 0; clear = 0; lap = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        total++;
        if (dut_out() !== 11'd0) begin
            bad++; $display("FAIL reset_outputs: got %h want 000", dut_out());
        end
        step(0, 1, 0, 0, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 1, 0, 1);
        total++;
        if (dut_out() !== 11'd0) begin
            bad++; $display("FAIL idle_ignores: got %h want 000", dut_out());
        end
    endtask

    task automatic test_count();
        step(1, 0, 0, 0, 1);
        total++;
        if (running !== 1'b1) begin
            bad++; $display("FAIL start_running: got %b want 1", running);
        end
        for (int e = 1; e <= 40; e++) begin
            step(0, 0, 0, 0, 1);
            if (e == 3 || e == 4 || e == 8) begin
                total++;
                if (units !== ((e == 3) ? 4'd0 : 4'(e / 4))) begin
                    bad++; $display("FAIL units_edge%0d: got %0d want %0d", e, units, e / 4);
                end
            end
        end
        total++;
        if ({tens, units} !== 8'h10) begin
            bad++; $display("FAIL carry_edge40: got %h want 10", {tens, units});
        end
    endtask

    task automatic test_wrap();
        int n = 0;
        int pulses = 0;
        while (m_secs != 59 && n < 400) begin
            step(0, 0, 0, 0, 1); n++;
        end
        total++;
        if (m_secs != 59 || dut_out() !== model_out()) begin
            bad++; $display("FAIL reach_59: got %h want %h", dut_out(), model_out());
        end
        for (int i = 0; i < 2 * TD; i++) begin
            step(0, 0, 0, 0, 1);
            pulses += int'(wrap);
            total++;
            if (dut_out() !== model_out()) begin
                bad++; $display("FAIL wrap_cycle%0d: got %h want %h", i, dut_out(), model_out());
            end
        end
        total++;
        if (pulses != 1 || running !== 1'b1) begin
            bad++; $display("FAIL wrap_pulses: got %0d/%b want 1/1", pulses, running);
        end
    endtask

    task automatic test_pause();
        int n = 0;
        logic [7:0] held;
        while (m_phase != 1 && n < 10) begin
            step(0, 0, 0, 0, 1); n++;
        end
        step(0, 1, 0, 0, 1);
        held = {tens, units};
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1);
        total++;
        if ({tens, units} !== held || running !== 1'b0) begin
            bad++; $display("FAIL pause_hold: got %h/%b want %h/0", {tens, units}, running, held);
        end
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        total++;
        if ({tens, units} !== held) begin
            bad++; $display("FAIL resume_early: got %h want %h", {tens, units}, held);
        end
        step(0, 0, 0, 0, 1);
        total++;
        if (dut_out() !== model_out() || {tens, units} === held) begin
            bad++; $display("FAIL resume_tick: got %h want %h", dut_out(), model_out());
        end
    endtask

    task automatic test_lap();
        int n = 0;
        step(0, 0, 1, 0, 1);
        step(1, 0, 0, 0, 1);
        while (m_secs != 12 && n < 100) begin
            step(0, 0, 0, 0, 1); n++;
        end
        step(0, 0, 0, 1, 1);
        n = 0;
        while (m_secs != 15 && n < 100) begin
            step(0, 0, 0, 0, 1); n++;
            total++;
            if ({tens, units} !== 8'h12 || lap_active !== 1'b1) begin
                bad++; $display("FAIL lap_frozen: got %h/%b want 12/1", {tens, units}, lap_active);
            end
        end
        step(0, 0, 0, 1, 1);
        total++;
        if ({tens, units} !== 8'h15 || lap_active !== 1'b0) begin
            bad++; $display("FAIL lap_release: got %h/%b want 15/0", {tens, units}, lap_active);
        end
        step(0, 0, 0, 1, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        total++;
        if (dut_out() !== model_out() || m_mode != 2 || m_secs == 15) begin
            bad++; $display("FAIL lap_stop: got %h want %h", dut_out(), model_out());
        end
    endtask

    task automatic test_clear_prio();
        int n = 0;
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(1, 1, 1, 0, 1);
        total++;
        if (dut_out() !== 11'd0) begin
            bad++; $display("FAIL clear_prio: got %h want 000", dut_out());
        end
        step(1, 0, 0, 0, 1);
        while (m_secs != 37 && n < 300) begin
            step(0, 0, 0, 0, 1); n++;
        end
        total++;
        if ({tens, units} !== 8'h37) begin
            bad++; $display("FAIL reach_37: got %h want 37", {tens, units});
        end
        step(0, 0, 0, 0, 0);
        total++;
        if (dut_out() !== 11'd0) begin
            bad++; $display("FAIL midrun_reset: got %h want 000", dut_out());
        end
        step(0, 0, 0, 0, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 40) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 200) != 0);
            total++;
            if (dut_out() !== model_out()) begin
                bad++; $display("FAIL random_%0d: got %h want %h", i, dut_out(), model_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_wrap();
        test_pause();
        test_lap();
        test_clear_prio();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
